smc_qbus_master: RTL and testbench

//  Q-bus initiator for the SMC register file: accepts register read/write commands on a

---
 rtl/smc_pkg.sv | 43 ++++
 rtl/smc_qbus_master_if.sv | 35 +++
 rtl/smc_cmd_fifo.sv | 62 ++++++
 rtl/smc_qbus_master.sv | 140 ++++++++++++++
 tb/tb_smc_qbus_master.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smc_pkg.sv
// ============================================================================
// Module : smc_pkg
// Brief  : SMC register map, address legality check and Q-bus master types.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package smc_pkg;

    localparam logic [6:0] C_SMC_REG_CTRL   = 7'h00;
    localparam logic [6:0] C_SMC_REG_STAT   = 7'h02;
    localparam logic [6:0] C_SMC_REG_IRQ    = 7'h03;
    localparam logic [6:0] C_SMC_BANK8_LO   = 7'h10;
    localparam logic [6:0] C_SMC_BANK8_HI   = 7'h1B;
    localparam logic [6:0] C_SMC_BANK16_LO  = 7'h20;
    localparam logic [6:0] C_SMC_BANK16_HI  = 7'h36;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } qm_state_t;

    typedef struct packed {
        logic        write;
        logic [6:0]  addr;
        logic [15:0] wdata;
    } qm_cmd_t;

    // The 16-bit bank only decodes even addresses.
    function automatic logic smc_addr_legal(input logic [6:0] addr);
        logic ok;
        ok = (addr == C_SMC_REG_CTRL) || (addr == C_SMC_REG_STAT) || (addr == C_SMC_REG_IRQ);
        ok = ok || ((addr >= C_SMC_BANK8_LO) && (addr <= C_SMC_BANK8_HI));
        ok = ok || ((addr >= C_SMC_BANK16_LO) && (addr <= C_SMC_BANK16_HI) && !addr[0]);
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/smc_qbus_master_if.sv
// ============================================================================
// Module : smc_qbus_master_if
// Brief  : Command/response handshake and Q-bus signals of the SMC bus master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface smc_qbus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        QSEL;
    logic        QWRITE;
    logic [6:0]  QADDR;
    logic [15:0] QDATAIN;
    logic [15:0] QDATAOUT;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, QDATAOUT,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, QSEL, QWRITE, QADDR, QDATAIN
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, QDATAOUT,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, QSEL, QWRITE, QADDR, QDATAIN
    );
endinterface

`default_nettype wire

// File: rtl/smc_cmd_fifo.sv
// ============================================================================
// Module : smc_cmd_fifo
// Brief  : Synchronous command FIFO with full/empty flags, power-of-2 depth.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module smc_cmd_fifo
    import smc_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_push,
    input  qm_cmd_t   i_data,
    input  wire logic i_pop,
    output qm_cmd_t   o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int c_PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL_CNT = CMD_DEPTH[c_PTR_W:0];

    qm_cmd_t            r_mem [CMD_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because the depth is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/smc_qbus_master.sv
// ============================================================================
// Module : smc_qbus_master
// Brief  : Q-bus initiator: buffers register commands, runs one bus access at a
//          time and returns one response per command.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module smc_qbus_master
    import smc_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  wire logic          QCLK,
    input  wire logic          QRESET_N,
    smc_qbus_master_if.master  bus
);

    qm_state_t   r_state;
    qm_state_t   w_state_nxt;
    qm_cmd_t     w_fifo_din;
    qm_cmd_t     w_fifo_head;
    qm_cmd_t     r_cmd;
    logic        r_cmd_vld;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;
    logic        w_dispatch;
    logic        w_legal;
    logic        w_issue_wr;
    logic        w_issue_rd;
    logic        r_qsel;
    logic        r_qwrite;
    logic [6:0]  r_qaddr;
    logic [15:0] r_qdatain;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [15:0] r_rsp_rdata;

    assign w_fifo_din = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    smc_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (QCLK),
        .rst_n   (QRESET_N),
        .i_push  (bus.cmd_valid),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The head entry is staged in r_cmd for one IDLE cycle before dispatch,
    // which places the bus access two cycles after the accept edge.
    assign w_pop      = (r_state == IDLE) & ~r_cmd_vld & ~w_fifo_empty;
    assign w_dispatch = (r_state == IDLE) & r_cmd_vld;
    assign w_legal    = smc_addr_legal(r_cmd.addr);
    assign w_issue_wr = (w_state_nxt == WR);
    assign w_issue_rd = (w_state_nxt == RD_ISSUE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_cmd_vld) begin
                    if (!w_legal)         w_state_nxt = RESP;
                    else if (r_cmd.write) w_state_nxt = WR;
                    else                  w_state_nxt = RD_ISSUE;
                end
            end
            WR:       w_state_nxt = RESP;
            RD_ISSUE: w_state_nxt = RD_WAIT;
            RD_WAIT:  w_state_nxt = RESP;
            RESP:     if (bus.rsp_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge QCLK or negedge QRESET_N) begin
        if (!QRESET_N) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_cmd_vld   <= 1'b0;
            r_qsel      <= 1'b0;
            r_qwrite    <= 1'b0;
            r_qaddr     <= '0;
            r_qdatain   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_pop) begin
                r_cmd     <= w_fifo_head;
                r_cmd_vld <= 1'b1;
            end else if (w_dispatch) begin
                r_cmd_vld <= 1'b0;
            end

            r_qsel    <= w_issue_wr | w_issue_rd;
            r_qwrite  <= w_issue_wr;
            r_qaddr   <= (w_issue_wr | w_issue_rd) ? r_cmd.addr : '0;
            r_qdatain <= w_issue_wr ? r_cmd.wdata : '0;

            // QDATAOUT is registered in the responder, so it is valid while in RD_WAIT.
            if (w_dispatch && !w_legal) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end else if (r_state == WR) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end else if (r_state == RD_WAIT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= bus.QDATAOUT;
            end else if ((r_state == RESP) && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign bus.cmd_ready = ~w_fifo_full;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.QSEL      = r_qsel;
    assign bus.QWRITE    = r_qwrite;
    assign bus.QADDR     = r_qaddr;
    assign bus.QDATAIN   = r_qdatain;

endmodule

`default_nettype wire

// File: tb/tb_smc_qbus_master.sv
// ============================================================================
// Module : tb_smc_qbus_master
// Brief  : Scoreboard bench for smc_qbus_master with a behavioural SMC responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_smc_qbus_master;

    localparam int CMD_DEPTH = 4;

    logic QCLK     = 1'b0;
    logic QRESET_N = 1'b0;
    logic QRESET;
    assign QRESET = ~QRESET_N;

    smc_qbus_master_if qif ();

    smc_qbus_master #(
        .CMD_DEPTH (CMD_DEPTH)
    ) dut (
        .QCLK     (QCLK),
        .QRESET_N (QRESET_N),
        .bus      (qif)
    );

    always #5 QCLK = ~QCLK;

    int n_vec    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int qsel_cnt = 0;
    int rdy_mode = 0;   // 0: always ready, 1: hold off, 2: alternate

    logic [16:0] rsp_q [$];   // {err, rdata}
    logic [23:0] bus_q [$];   // {write, addr, wdata}
    logic [15:0] ref_mem [128];
    logic [6:0]  legal_q [$];

    always @(posedge QCLK) cyc <= cyc + 1;

    // ---------------- reference rules ----------------
    function automatic bit ref_legal(input int a);
        if (a == 0 || a == 2 || a == 3) return 1'b1;
        if (a >= 16 && a <= 27)         return 1'b1;
        if (a >= 32 && a <= 54 && (a % 2) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_is8(input int a);
        return (a >= 16 && a <= 27);
    endfunction

    function automatic void model_accept(input bit w, input logic [6:0] a, input logic [15:0] d);
        if (!ref_legal(int'(a))) begin
            rsp_q.push_back({1'b1, 16'h0000});
        end else if (w) begin
            ref_mem[a] = ref_is8(int'(a)) ? (d & 16'h00FF) : d;
            rsp_q.push_back({1'b0, 16'h0000});
            bus_q.push_back({1'b1, a, d});
        end else begin
            rsp_q.push_back({1'b0, ref_mem[a]});
            bus_q.push_back({1'b0, a, 16'h0000});
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SMC responder ----------------
    logic [15:0] resp_mem [128];
    always_ff @(posedge QCLK or posedge QRESET) begin
        if (QRESET) begin
            for (int i = 0; i < 128; i++) resp_mem[i] <= '0;
            qif.QDATAOUT <= '0;
        end else if (qif.QSEL && qif.QWRITE) begin
            resp_mem[qif.QADDR] <= ref_is8(int'(qif.QADDR)) ? {8'h00, qif.QDATAIN[7:0]} : qif.QDATAIN;
        end else if (qif.QSEL) begin
            qif.QDATAOUT <= resp_mem[qif.QADDR];
        end
    end

    // ---------------- response-ready driver ----------------
    initial begin
        qif.rsp_ready = 1'b0;
        forever begin
            @(posedge QCLK);
            #1;
            case (rdy_mode)
                0:       qif.rsp_ready = 1'b1;
                1:       qif.rsp_ready = 1'b0;
                default: qif.rsp_ready = ~qif.rsp_ready;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_qsel = 1'b0;
    logic [23:0] exp_bus;
    logic [16:0] exp_rsp;

    always @(negedge QCLK) begin
        if (qif.QSEL) begin
            qsel_cnt++;
            check("qsel_back_to_back", {31'd0, prev_qsel}, 32'd0);
            if (bus_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_qsel: addr 0x%0h seen, expected no bus access", qif.QADDR);
            end else begin
                exp_bus = bus_q.pop_front();
                check("bus_write", {31'd0, qif.QWRITE}, {31'd0, exp_bus[23]});
                check("bus_addr",  {25'd0, qif.QADDR}, {25'd0, exp_bus[22:16]});
                if (exp_bus[23]) check("bus_wdata", {16'd0, qif.QDATAIN}, {16'd0, exp_bus[15:0]});
            end
        end else begin
            check("bus_idle", {8'd0, qif.QWRITE, qif.QADDR, qif.QDATAIN}, 32'd0);
        end
        prev_qsel = qif.QSEL;

        if (qif.rsp_valid && qif.rsp_ready) begin
            if (rsp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: rdata 0x%0h err %0d, expected no response", qif.rsp_rdata, qif.rsp_err);
            end else begin
                exp_rsp = rsp_q.pop_front();
                check("rsp_rdata", {16'd0, qif.rsp_rdata}, {16'd0, exp_rsp[15:0]});
                check("rsp_err",   {31'd0, qif.rsp_err}, {31'd0, exp_rsp[16]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit w, input logic [6:0] a, input logic [15:0] d,
                        input int max_wait, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        qif.cmd_valid = 1'b1;
        qif.cmd_write = w;
        qif.cmd_addr  = a;
        qif.cmd_wdata = d;
        while (n < max_wait) begin
            @(negedge QCLK);
            if (qif.cmd_ready) begin
                @(posedge QCLK);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge QCLK);
            #1;
            n++;
        end
        qif.cmd_valid = 1'b0;
        qif.cmd_write = 1'b0;
        qif.cmd_addr  = '0;
        qif.cmd_wdata = '0;
        if (ok) model_accept(w, a, d);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 500) begin
            @(posedge QCLK);
            #1;
            n++;
        end
        if (n >= 500) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_drain: %0d responses pending, expected 0", name, rsp_q.size());
        end
        repeat (2) @(posedge QCLK);
        #1;
    endtask

    task automatic timed(input string name, input bit w, input logic [6:0] a,
                         input logic [15:0] d, input int exp_qsel, input int exp_rsp);
        bit ok;
        int t0;
        int t_q;
        int t_r;
        t_q = -1;
        t_r = -1;
        send(w, a, d, 50, ok);
        check({name, "_accept"}, {31'd0, ok}, 32'd1);
        t0 = cyc;
        for (int i = 0; i < 20 && t_r < 0; i++) begin
            @(negedge QCLK);
            if (qif.QSEL && t_q < 0) t_q = cyc - t0;
            if (qif.rsp_valid)       t_r = cyc - t0;
        end
        check({name, "_qsel_cycle"}, t_q, exp_qsel);
        check({name, "_rsp_cycle"},  t_r, exp_rsp);
        @(posedge QCLK);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          ok;
        int          accepted;
        int          snap;
        logic [6:0]  a;
        logic [15:0] d;

        qif.cmd_valid = 1'b0;
        qif.cmd_write = 1'b0;
        qif.cmd_addr  = '0;
        qif.cmd_wdata = '0;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = '0;
            if (ref_legal(i)) legal_q.push_back(7'(i));
        end

        repeat (3) @(posedge QCLK);
        #1;
        check("rst_cmd_ready", {31'd0, qif.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, qif.rsp_valid}, 32'd0);
        check("rst_rsp_bits",  {15'd0, qif.rsp_err, qif.rsp_rdata}, 32'd0);
        check("rst_bus",       {7'd0, qif.QSEL, qif.QWRITE, qif.QADDR, qif.QDATAIN}, 32'd0);
        @(negedge QCLK);
        QRESET_N = 1'b1;
        @(posedge QCLK);
        #1;

        // Basic write/read and latency
        rdy_mode = 0;
        timed("wr00", 1'b1, 7'h00, 16'h1234, 2, 3);
        drain("t1w");
        timed("rd00", 1'b0, 7'h00, 16'h0000, 2, 4);
        drain("t1r");

        // 8-bit register truncation
        timed("wr13", 1'b1, 7'h13, 16'hABCD, 2, 3);
        drain("t2w");
        timed("rd13", 1'b0, 7'h13, 16'h0000, 2, 4);
        drain("t2r");

        // Illegal addresses
        timed("rd01", 1'b0, 7'h01, 16'h0000, -1, 2);
        drain("t3r");
        timed("wr21", 1'b1, 7'h21, 16'h5555, -1, 2);
        drain("t3w");

        // FIFO fill with responses held off
        rdy_mode = 1;
        @(posedge QCLK);
        #1;
        snap     = qsel_cnt;
        accepted = 0;
        for (int i = 0; i < CMD_DEPTH + 2; i++) begin
            send(1'b1, 7'(32 + 2 * i), 16'(16'h1000 + i), 10, ok);
            if (ok) accepted++;
        end
        check("fill_accepts",   accepted, CMD_DEPTH + 1);
        check("fill_cmd_ready", {31'd0, qif.cmd_ready}, 32'd0);
        check("fill_qsel_held", qsel_cnt - snap, 1);
        rdy_mode = 0;
        send(1'b1, 7'(32 + 2 * (CMD_DEPTH + 1)), 16'(16'h1000 + CMD_DEPTH + 1), 200, ok);
        check("fill_last_accept", {31'd0, ok}, 32'd1);
        for (int i = 0; i < CMD_DEPTH + 2; i++) begin
            send(1'b0, 7'(32 + 2 * i), 16'h0000, 200, ok);
            check("fill_readback_accept", {31'd0, ok}, 32'd1);
        end
        drain("t4");

        // Mixed random stream with alternating rsp_ready
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(0, 127));
            else                           a = legal_q[$urandom_range(0, legal_q.size() - 1)];
            d = 16'($urandom);
            send(1'($urandom_range(0, 1)), a, d, 200, ok);
            check("mix_accept", {31'd0, ok}, 32'd1);
        end
        drain("t5");

        // Reset while a read is on the bus
        rdy_mode = 0;
        send(1'b0, 7'h02, 16'h0000, 50, ok);
        check("rst_rd_accept", {31'd0, ok}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge QCLK);
            #1;
            if (qif.QSEL) ok = 1'b1;
        end
        check("rst_saw_qsel", {31'd0, ok}, 32'd1);
        QRESET_N = 1'b0;
        rsp_q.delete();
        bus_q.delete();
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        #1;
        check("rst_async_qsel",  {31'd0, qif.QSEL}, 32'd0);
        check("rst_async_rsp",   {31'd0, qif.rsp_valid}, 32'd0);
        check("rst_async_ready", {31'd0, qif.cmd_ready}, 32'd1);
        repeat (2) @(negedge QCLK);
        QRESET_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge QCLK);
            #1;
            check("post_rst_rsp_valid", {31'd0, qif.rsp_valid}, 32'd0);
            check("post_rst_cmd_ready", {31'd0, qif.cmd_ready}, 32'd1);
        end
        timed("post_rst_wr", 1'b1, 7'h02, 16'h5A5A, 2, 3);
        drain("t6w");
        timed("post_rst_rd", 1'b0, 7'h02, 16'h0000, 2, 4);
        drain("t6r");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
